// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for bin2bcd_seq.
// Signals:
//   start    - conversion request (master -> slave)
//   bin      - unsigned binary value, WIDTH bits (master -> slave)
//   busy     - conversion in progress (slave -> master)
//   done     - one-cycle result-valid pulse (slave -> master)
//   bcd      - packed BCD result, 4*DIGITS bits, digit 0 in bits [3:0] (slave -> master)
//   overflow - last accepted bin exceeded 10^DIGITS-1 (slave -> master)
//   blank    - leading-zero blank mask, one bit per digit (slave -> master)
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned DIGITS = 6
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the per-digit 7-segment decoders.
// Optional feature macro: LEADING_ZERO_BLANK_EN (registered leading-zero
// blank mask; when undefined, blank is tied to zero).
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - bin2bcd_seq_if.slave: start/bin in; busy/done/bcd/overflow/blank out
// Latency from accepted start edge to done/bcd update is WIDTH clocks.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic              clk,
    input  logic              reset,
    bin2bcd_seq_if.slave      bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;

    state_t             w_state_n;
    logic [WIDTH-1:0]   w_shreg_n;
    logic [BCD_W-1:0]   w_scratch_n;
    logic               w_carry_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic               w_busy_n;
    logic               w_done_n;
    logic [BCD_W-1:0]   w_bcd_n;
    logic               w_overflow_n;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shift_scratch;
    logic               w_carry_out;

`ifdef LEADING_ZERO_BLANK_EN
    // Every digit blanked except digit 0, which always shows.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank_n;
    logic [DIGITS-1:0]  w_blank_new;
`endif

    // Add 3 to every scratch digit >= 5 ahead of the shift.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end else begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4];
            end
        end
    end

    // Shift {scratch, shreg} left by one; the top scratch bit falls out as carry.
    assign w_shift_scratch = {w_adj[BCD_W-2:0], r_shreg[WIDTH-1]};
    assign w_carry_out     = w_adj[BCD_W-1];

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digit i (i >= 1) when it and every digit above it are zero.
    always_comb begin
        logic zero_above;
        w_blank_new = '0;
        zero_above  = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above     = zero_above & (w_shift_scratch[4*i +: 4] == 4'd0);
            w_blank_new[i] = zero_above;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank    <= BLANK_RST;
`endif
        end else begin
            r_state    <= w_state_n;
            r_shreg    <= w_shreg_n;
            r_scratch  <= w_scratch_n;
            r_carry    <= w_carry_n;
            r_cnt      <= w_cnt_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_bcd      <= w_bcd_n;
            r_overflow <= w_overflow_n;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank    <= w_blank_n;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n    = r_state;
        w_shreg_n    = r_shreg;
        w_scratch_n  = r_scratch;
        w_carry_n    = r_carry;
        w_cnt_n      = r_cnt;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_bcd_n      = r_bcd;
        w_overflow_n = r_overflow;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_n    = r_blank;
`endif

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_shreg_n   = bus.bin;
                    w_scratch_n = '0;
                    w_carry_n   = 1'b0;
                    w_cnt_n     = CNT_W'(WIDTH);
                    w_busy_n    = 1'b1;
                    w_state_n   = SHIFT;
                end
            end

            SHIFT: begin
                w_scratch_n = w_shift_scratch;
                w_shreg_n   = {r_shreg[WIDTH-2:0], 1'b0};
                w_carry_n   = r_carry | w_carry_out;
                w_cnt_n     = r_cnt - CNT_W'(1);
                // Counter at 1 means this edge performs the final shift.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_n    = IDLE;
                    w_busy_n     = 1'b0;
                    w_done_n     = 1'b1;
                    w_bcd_n      = w_shift_scratch;
                    w_overflow_n = r_carry | w_carry_out;
`ifdef LEADING_ZERO_BLANK_EN
                    w_blank_n    = w_blank_new;
`endif
                end
            end

            default: begin
                w_state_n = IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;
`ifdef LEADING_ZERO_BLANK_EN
    assign bus.blank    = r_blank;
`else
    assign bus.blank    = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=20, DIGITS=6).
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(20), .DIGITS(6)) bus ();

    bin2bcd_seq #(.WIDTH(20), .DIGITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Blank expectation only applies when the blanking feature is built in.
    function automatic logic [5:0] exp_blank(input logic [5:0] on_val);
`ifdef LEADING_ZERO_BLANK_EN
        return on_val;
`else
        return 6'b000000;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full conversion: latency, result, status and single-cycle done.
    task automatic run_conv(input string tag, input logic [19:0] b, input logic [23:0] eb,
                            input logic eo, input logic [5:0] ebl);
        int lat;
        lat = 0;
        bus.start = 1'b1;
        bus.bin   = b;
        tick;
        bus.start = 1'b0;
        bus.bin   = 20'hABCDE;
        check_val({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd20);
        check_val({tag, "_bcd"}, 32'(bus.bcd), 32'(eb));
        check_val({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        check_val({tag, "_blank"}, 32'(bus.blank), 32'(exp_blank(ebl)));
        check_val({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        tick;
        check_val({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n_done;
        int first;
        int d[4];

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        tick;
        tick;
        reset = 1'b0;

        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_bcd", 32'(bus.bcd), 32'd0);
        check_val("rst_overflow", 32'(bus.overflow), 32'd0);
        check_val("rst_blank", 32'(bus.blank), 32'(exp_blank(6'b111110)));

        run_conv("zero",    20'd0,       24'h000000, 1'b0, 6'b111110);
        run_conv("c123456", 20'd123456,  24'h123456, 1'b0, 6'b000000);
        run_conv("c999999", 20'd999999,  24'h999999, 1'b0, 6'b000000);
        run_conv("c1e6",    20'd1000000, 24'h000000, 1'b1, 6'b111110);
        run_conv("cmax",    20'd1048575, 24'h048575, 1'b1, 6'b100000);

        // Reset mid-conversion aborts without a done pulse.
        bus.start = 1'b1;
        bus.bin   = 20'd555;
        tick;
        bus.start = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        check_val("abort_done", 32'(bus.done), 32'd0);
        check_val("abort_bcd", 32'(bus.bcd), 32'd0);
        check_val("abort_overflow", 32'(bus.overflow), 32'd0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (bus.done) n_done++;
        end
        check_val("abort_no_done", 32'(n_done), 32'd0);
        run_conv("c9", 20'd9, 24'h000009, 1'b0, 6'b111110);

        // Start while busy is ignored.
        bus.start = 1'b1;
        bus.bin   = 20'd42;
        tick;
        bus.start = 1'b0;
        n_done = 0;
        first  = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.bin   = 20'd7;
            end else begin
                bus.start = 1'b0;
            end
            tick;
            if (bus.done) begin
                n_done++;
                if (first == 0) first = k;
            end
        end
        check_val("ign_done_count", 32'(n_done), 32'd1);
        check_val("ign_latency", 32'(first), 32'd20);
        check_val("ign_bcd", 32'(bus.bcd), 32'h000042);
        check_val("ign_blank", 32'(bus.blank), 32'(exp_blank(6'b111100)));

        // Start held high: a new conversion starts in every done cycle.
        bus.start = 1'b1;
        bus.bin   = 20'd100;
        tick;
        n_done = 0;
        for (int k = 1; k <= 70; k++) begin
            tick;
            if (bus.done) begin
                if (n_done < 4) d[n_done] = k;
                n_done++;
            end
        end
        bus.start = 1'b0;
        check_val("b2b_done_count", 32'(n_done), 32'd3);
        check_val("b2b_first", 32'(d[0]), 32'd20);
        check_val("b2b_gap1", 32'(d[1] - d[0]), 32'd21);
        check_val("b2b_gap2", 32'(d[2] - d[1]), 32'd21);
        check_val("b2b_bcd", 32'(bus.bcd), 32'h000100);
        check_val("b2b_blank", 32'(bus.blank), 32'(exp_blank(6'b111000)));
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (bus.done) begin
                first = k;
                break;
            end
        end
        // Last accepted request (at cycle 63) completes at cycle 83.
        check_val("b2b_tail_done", 32'(first), 32'd13);
        check_val("b2b_tail_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
